// File: rtl/seq_ser_pkg.sv
// Shared definitions for seq_bit_serializer: state encoding, default width, counter sizing.
package seq_ser_pkg;

    localparam int SEQ_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } seq_ser_state_e;

    // Counter must hold DATA_W itself (parity cycle parks it there).
    function automatic int seq_cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the 1101 detectors; gapless back-to-back frames.
// Optional even-parity trailer bit when SEQ_SER_PARITY_EN is defined.
module seq_bit_serializer
    import seq_ser_pkg::*;
#(
    parameter int DATA_W     = SEQ_DATA_W,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              sout,
    output logic              sout_valid,
    output logic              busy,
    output logic              frame_done,
    output logic [1:0]        state_dbg
);

    localparam int CNT_W = seq_cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
`ifdef SEQ_SER_PARITY_EN
    localparam logic [1:0] ST_PARITY = PARITY;
`else
    localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(DATA_W - 2);
`endif

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shreg;
    logic              xfer;
`ifdef SEQ_SER_PARITY_EN
    logic              par_r;
`endif

    function automatic logic head_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // Handshake: a word transfers on a rising edge where din_valid && din_ready;
    // din_ready depends only on state (and rst), never on din_valid.
    always_comb begin
        din_ready = 1'b0;
        if (rst) begin
`ifdef SEQ_SER_PARITY_EN
            din_ready = (state == ST_IDLE) || (state == ST_PARITY);
`else
            din_ready = (state == ST_IDLE) || (state == ST_SHIFT && cnt == LAST_CNT);
`endif
        end
    end

    assign xfer      = din_valid && din_ready;
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            shreg      <= '0;
            sout       <= IDLE_LEVEL;
            sout_valid <= 1'b0;
            frame_done <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
            par_r      <= 1'b0;
`endif
        end else if (xfer) begin
            // First bit leaves on the accepting edge; the register keeps the rest.
            state      <= ST_SHIFT;
            cnt        <= '0;
            shreg      <= advance(din);
            sout       <= head_bit(din);
            sout_valid <= 1'b1;
            frame_done <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
            par_r      <= ^din;
`endif
        end else if (state == ST_SHIFT && cnt != LAST_CNT) begin
            cnt        <= cnt + 1'b1;
            shreg      <= advance(shreg);
            sout       <= head_bit(shreg);
            sout_valid <= 1'b1;
`ifdef SEQ_SER_PARITY_EN
            frame_done <= 1'b0;
        end else if (state == ST_SHIFT) begin
            state      <= ST_PARITY;
            cnt        <= CNT_W'(DATA_W);
            sout       <= par_r;
            sout_valid <= 1'b1;
            frame_done <= 1'b1;
`else
            frame_done <= (cnt == PRE_LAST_CNT);
`endif
        end else begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sout       <= IDLE_LEVEL;
            sout_valid <= 1'b0;
            frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer (MSB-first instance a, LSB-first idle-high instance b).
module tb_seq_bit_serializer;

    localparam int W = 8;
`ifdef SEQ_SER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FLEN = W + (PAR ? 1 : 0);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] a_din = '0;
    logic a_din_valid = 1'b0;
    logic a_din_ready, a_sout, a_sout_valid, a_busy, a_frame_done;
    logic [1:0] a_state;

    logic [W-1:0] b_din = '0;
    logic b_din_valid = 1'b0;
    logic b_din_ready, b_sout, b_sout_valid, b_busy, b_frame_done;
    logic [1:0] b_state;

    seq_bit_serializer #(.DATA_W(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
        .clk(clk), .rst(rst), .din(a_din), .din_valid(a_din_valid), .din_ready(a_din_ready),
        .sout(a_sout), .sout_valid(a_sout_valid), .busy(a_busy), .frame_done(a_frame_done),
        .state_dbg(a_state)
    );

    seq_bit_serializer #(.DATA_W(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_b (
        .clk(clk), .rst(rst), .din(b_din), .din_valid(b_din_valid), .din_ready(b_din_ready),
        .sout(b_sout), .sout_valid(b_sout_valid), .busy(b_busy), .frame_done(b_frame_done),
        .state_dbg(b_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard entries are {frame_done, sout} for each expected frame bit of instance a.
    logic [1:0] exp_q[$];
    logic [1:0] exp_e;
    bit mon_en = 1'b0;
    int run = 0;
    int last_run = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (a_sout_valid) begin
                run++;
                if (exp_q.size() == 0) begin
                    check("unexpected_bit", 32'd1, 32'd0);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("sout", {31'd0, a_sout}, {31'd0, exp_e[0]});
                    check("frame_done", {31'd0, a_frame_done}, {31'd0, exp_e[1]});
                    check("busy", {31'd0, a_busy}, 32'd1);
                end
            end else begin
                if (run != 0) last_run = run;
                run = 0;
                check("idle_sout", {31'd0, a_sout}, 32'd0);
                check("idle_frame_done", {31'd0, a_frame_done}, 32'd0);
                check("idle_busy", {31'd0, a_busy}, 32'd0);
            end
        end
    end

    // stream[7] is the first bit expected on the wire.
    task automatic push_stream(input logic [7:0] stream, input logic par);
        for (int i = 0; i < W; i++)
            exp_q.push_back({(!PAR && i == W - 1), stream[W-1-i]});
        if (PAR) exp_q.push_back({1'b1, par});
    endtask

    // Called just after a falling edge; returns on the falling edge after the accepting edge
    // with din_valid still high.
    task automatic send(input logic [7:0] word, input logic [7:0] stream, input logic par,
                        output int waits);
        a_din = word;
        a_din_valid = 1'b1;
        waits = 0;
        #1;
        while (!a_din_ready && waits < 40) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!a_din_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            a_din_valid = 1'b0;
        end else begin
            push_stream(stream, par);
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || a_sout_valid) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check("drain_timeout", 32'd0, 32'd1);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [7:0] b_stream;

        // Reset held with valid words offered: nothing may be taken.
        a_din = 8'hFF;
        a_din_valid = 1'b1;
        b_din = 8'hFF;
        b_din_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            check("rst_din_ready", {31'd0, a_din_ready}, 32'd0);
            check("rst_sout", {31'd0, a_sout}, 32'd0);
            check("rst_sout_valid", {31'd0, a_sout_valid}, 32'd0);
            check("rst_busy", {31'd0, a_busy}, 32'd0);
            check("rst_frame_done", {31'd0, a_frame_done}, 32'd0);
            check("rst_b_sout", {31'd0, b_sout}, 32'd1);
            check("rst_b_din_ready", {31'd0, b_din_ready}, 32'd0);
        end
        a_din_valid = 1'b0;
        b_din_valid = 1'b0;
        rst = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        #1;
        check("idle_din_ready", {31'd0, a_din_ready}, 32'd1);
        check("idle_state", {30'd0, a_state}, 32'd0);

        // Single word 0xD0, MSB first.
        send(8'hD0, 8'b1101_0000, 1'b1, w);
        a_din_valid = 1'b0;
        #1;
        check("busy_din_ready", {31'd0, a_din_ready}, 32'd0);
        wait_idle();
        check("single_run", last_run, FLEN);

        // Back-to-back 0xDD then 0x0D with valid held.
        send(8'hDD, 8'b1101_1101, 1'b0, w);
        send(8'h0D, 8'b0000_1101, 1'b1, w);
        check("b2b_accept_wait", w, FLEN - 1);
        a_din_valid = 1'b0;
        wait_idle();
        check("b2b_run", last_run, 2 * FLEN);

        // Backpressure: 0xAA offered during bit 3 of a 0xD0 frame.
        send(8'hD0, 8'b1101_0000, 1'b1, w);
        a_din_valid = 1'b0;
        repeat (3) @(negedge clk);
        send(8'hAA, 8'b1010_1010, 1'b0, w);
        check("bp_accept_wait", w, FLEN - 1 - 3);
        a_din_valid = 1'b0;
        wait_idle();
        check("bp_run", last_run, 2 * FLEN);

        // LSB-first instance b: 0x0B must appear as 1,1,0,1,0,0,0,0.
        b_stream = 8'b1101_0000;
        b_din = 8'h0B;
        b_din_valid = 1'b1;
        #1;
        check("b_din_ready", {31'd0, b_din_ready}, 32'd1);
        @(negedge clk);
        b_din_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            check("b_sout", {31'd0, b_sout}, {31'd0, b_stream[W-1-i]});
            check("b_sout_valid", {31'd0, b_sout_valid}, 32'd1);
            check("b_frame_done", {31'd0, b_frame_done}, {31'd0, (!PAR && i == W - 1)});
            @(negedge clk);
        end
        if (PAR) begin
            check("b_parity", {31'd0, b_sout}, 32'd1);
            check("b_parity_frame_done", {31'd0, b_frame_done}, 32'd1);
            @(negedge clk);
        end
        check("b_end_valid", {31'd0, b_sout_valid}, 32'd0);
        check("b_end_sout", {31'd0, b_sout}, 32'd1);
        check("b_end_busy", {31'd0, b_busy}, 32'd0);

        // Abort: reset after bit 3 of a 0xFF frame.
        send(8'hFF, 8'hFF, 1'b0, w);
        a_din_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        #1;
        check("abort_sout", {31'd0, a_sout}, 32'd0);
        check("abort_sout_valid", {31'd0, a_sout_valid}, 32'd0);
        check("abort_frame_done", {31'd0, a_frame_done}, 32'd0);
        check("abort_busy", {31'd0, a_busy}, 32'd0);
        check("abort_din_ready", {31'd0, a_din_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("post_abort_ready", {31'd0, a_din_ready}, 32'd1);
        repeat (3) @(negedge clk);
        check("post_abort_queue", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
